// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined signed ALU with optional saturation, status flags and an accumulator.
// Latency: a beat accepted at edge N is presented on out_* after edge N+1. Throughput is one beat per cycle.
// Backpressure: a full valid/ready skid-free pipe. in_ready = !s1_valid | out-stage advance, and nothing is dropped.
//
// Ports:
//   clk, rst_n                       clock; asynchronous active-low reset
//   in_valid/in_ready                operand handshake: in_a, in_b, in_op, in_acc
//   acc_clr                          synchronous accumulator clear, independent of handshakes
//   out_valid/out_ready              result handshake: out_res, out_ovf, out_zero, out_neg
//   acc_q                            current accumulator value
module alu_pipe #(
  parameter int WIDTH    = 6,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic [WIDTH-1:0] acc_q
);

  // Three guard bits cover the worst case |A*4| + |B/2| and |A| + |3B|.
  localparam int XW = WIDTH + 3;

  // Stage 1 operand register
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s1_acc;

  // Stage 2 output register
  logic             s2_valid;
  logic [WIDTH-1:0] res_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [WIDTH-1:0] acc_r;

  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;

  // Combinational datapath from the S1 registers
  logic [WIDTH-1:0]    op_a;
  logic signed [XW-1:0] ax;
  logic signed [XW-1:0] bx;
  logic signed [XW-1:0] diff;
  logic signed [XW-1:0] exact;
  logic [3:0]          top;
  logic                ovf;
  logic [WIDTH-1:0]    satv;
  logic [WIDTH-1:0]    res;

  // The accumulator is sampled here, at the S1->S2 transfer, so consecutive
  // accumulate beats always see the previous beat's result. A coincident
  // clear makes the accumulating beat start from zero.
  always_comb begin
    op_a = s1_a;
    if (s1_acc) begin
      op_a = acc_clr ? '0 : acc_r;
    end
  end

  always_comb begin
    ax    = {{3{op_a[WIDTH-1]}}, op_a};
    bx    = {{3{s1_b[WIDTH-1]}}, s1_b};
    diff  = '0;
    exact = '0;
    case (s1_op)
      2'b00: exact = (ax <<< 2) + (bx >>> 1);
      2'b01: exact = ax + bx + (bx <<< 1);
      2'b10: exact = -bx;
      default: begin
        diff  = (ax <<< 1) - bx;
        exact = diff[XW-1] ? -diff : diff;
      end
    endcase
  end

  // The exact value fits WIDTH bits only if the top guard bits and the
  // result sign bit all agree.
  always_comb begin
    top  = exact[XW-1:WIDTH-1];
    ovf  = !((top == 4'b0000) || (top == 4'b1111));
    satv = exact[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    res  = exact[WIDTH-1:0];
    if (SATURATE && ovf) begin
      res = satv;
    end
  end

  // Stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_acc   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_acc <= in_acc;
      end
    end
  end

  // Stage 2. Data and flags only load on a transfer, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s1_adv) begin
        res_q  <= res;
        ovf_q  <= ovf;
        zero_q <= (res == '0);
        neg_q  <= res[WIDTH-1];
      end
    end
  end

  // An accumulate transfer wins over a clear: the clear has already been
  // folded into its operand A above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (s1_adv && s1_acc) begin
      acc_r <= res;
    end else if (acc_clr) begin
      acc_r <= '0;
    end
  end

  assign out_valid = s2_valid;
  assign out_res   = res_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign out_neg   = neg_q;
  assign acc_q     = acc_r;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven bench for alu_pipe with a wrapping and a saturating instance sharing stimulus.
// Latency: expected results are queued at input handshake and compared when the output is valid.
// Backpressure: out_ready is forced or randomised; held outputs are compared against the queue head every cycle.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] in_a, in_b;
  logic [1:0] in_op;
  logic       in_acc;
  logic       acc_clr;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_ovf0, out_zero0, out_neg0;
  logic [5:0] out_res0, acc_q0;
  logic       in_ready1, out_valid1, out_ovf1, out_zero1, out_neg1;
  logic [5:0] out_res1, acc_q1;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(6), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_res(out_res0),
    .out_ovf(out_ovf0), .out_zero(out_zero0), .out_neg(out_neg0), .acc_q(acc_q0)
  );

  alu_pipe #(.WIDTH(6), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_res(out_res1),
    .out_ovf(out_ovf1), .out_zero(out_zero1), .out_neg(out_neg1), .acc_q(acc_q1)
  );

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [1:0] op;
    logic       acc;
    logic [5:0] rw;   // wrapped result
    logic       ovf;
    logic [5:0] rs;   // saturated result
  } vec_t;

  typedef struct {
    logic [5:0] rw;
    logic [5:0] rs;
    logic       ovf;
    logic       chk_acc;
    logic [5:0] acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   npop = 0;
  bit   rand_mode = 1'b0;
  logic force_rdy = 1'b1;
  vec_t tab[10];

  function automatic vec_t mk(int a, int b, int op, int rw, int ovf, int rs, int acc);
    vec_t v;
    v.a   = 6'(a);
    v.b   = 6'(b);
    v.op  = 2'(op);
    v.acc = 1'(acc);
    v.rw  = 6'(rw);
    v.ovf = 1'(ovf);
    v.rs  = 6'(rs);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge with in_valid still high.
  task automatic send(input vec_t v, input logic chk_acc, input logic [5:0] eacc);
    exp_t e;
    bit   ok = 1'b0;
    in_a = v.a; in_b = v.b; in_op = v.op; in_acc = v.acc; in_valid = 1'b1;
    e.rw = v.rw; e.rs = v.rs; e.ovf = v.ovf; e.chk_acc = chk_acc; e.acc = eacc;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (in_ready0) ok = 1'b1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready0 required=in_ready1");
    end else begin
      q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
    end
    @(posedge clk); #1;
  endtask

  // out_ready driver, applied a little after each rising edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : force_rdy;
    end
  end

  // Output monitor: the held beat must match the queue head every cycle it is valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid0) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%0d required=no_beat", out_res0);
        end else begin
          e = q[0];
          check("res_wrap",  32'(out_res0),  32'(e.rw));
          check("ovf_wrap",  32'(out_ovf0),  32'(e.ovf));
          check("zero_wrap", 32'(out_zero0), 32'(e.rw == 6'd0));
          check("neg_wrap",  32'(out_neg0),  32'(e.rw[5]));
          check("valid_sat", 32'(out_valid1), 32'd1);
          check("res_sat",   32'(out_res1),  32'(e.rs));
          check("ovf_sat",   32'(out_ovf1),  32'(e.ovf));
          check("zero_sat",  32'(out_zero1), 32'(e.rs == 6'd0));
          check("neg_sat",   32'(out_neg1),  32'(e.rs[5]));
          if (e.chk_acc) check("acc_q", 32'(acc_q0), 32'(e.acc));
          if (out_ready) begin
            void'(q.pop_front());
            npop++;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          a    b   op  wrap ovf  sat acc
    tab[0] = mk(3,   5,  0,  14,  0,  14, 0);
    tab[1] = mk(10,  5,  0, -22,  1,  31, 0);
    tab[2] = mk(0, -32,  2, -32,  1,  31, 0);
    tab[3] = mk(-16, 1,  3, -31,  1,  31, 0);
    tab[4] = mk(1,  -3,  1,  -8,  0,  -8, 0);
    tab[5] = mk(2,   4,  3,   0,  0,   0, 0);
    tab[6] = mk(-5, -3,  0, -22,  0, -22, 0);
    tab[7] = mk(-20,-5,  1,  29,  1, -32, 0);
    tab[8] = mk(0,   7,  2,  -7,  0,  -7, 0);
    tab[9] = mk(-3,  2,  3,   8,  0,   8, 0);

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_acc = 1'b0; acc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_res",   32'(out_res0),   32'd0);
    check("rst_out_ovf",   32'(out_ovf0),   32'd0);
    check("rst_out_zero",  32'(out_zero0),  32'd0);
    check("rst_out_neg",   32'(out_neg0),   32'd0);
    check("rst_acc_q",     32'(acc_q0),     32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", 32'(in_ready0), 32'd1);

    // First beat: one-cycle gap before the result appears
    send(tab[0], 1'b0, 6'd0);
    idle();
    @(negedge clk);
    check("latency_gap", 32'(out_valid0), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid0), 32'd1);
    @(posedge clk); #1;

    // Remaining table beats back-to-back at full throughput
    for (int i = 1; i < 10; i++) send(tab[i], 1'b0, 6'd0);
    idle();
    drain();

    // Accumulate chain: 3, 6, 9
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    send(mk(0, 1, 1, 3, 0, 3, 1), 1'b1, 6'd3);
    send(mk(0, 1, 1, 6, 0, 6, 1), 1'b1, 6'd6);
    send(mk(0, 1, 1, 9, 0, 9, 1), 1'b1, 6'd9);
    idle();
    drain();
    check("acc_after_chain", 32'(acc_q0), 32'd9);

    // Clear alone, then a chain whose third transfer coincides with a clear
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    check("acc_clr_only", 32'(acc_q0), 32'd0);
    send(mk(0, 1, 1, 3, 0, 3, 1), 1'b1, 6'd3);
    send(mk(0, 1, 1, 6, 0, 6, 1), 1'b1, 6'd6);
    send(mk(0, 1, 1, 3, 0, 3, 1), 1'b1, 6'd3);
    idle();
    acc_clr = 1'b1; @(posedge clk); #1; acc_clr = 1'b0;
    drain();
    check("acc_after_clr_chain", 32'(acc_q0), 32'd3);

    // Backpressure: five beats against a stalled sink, then random release
    force_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        for (int i = 4; i < 9; i++) send(tab[i], 1'b0, 6'd0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready0), 32'd0);
        check("bp_out_valid",    32'(out_valid0), 32'd1);
        check("bp_out_res_held", 32'(out_res0),   32'(tab[4].rw));
        force_rdy = 1'b1;
        rand_mode = 1'b1;
      end
    join
    drain();
    rand_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset with both stages full and a non-zero accumulator
    force_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(tab[0], 1'b0, 6'd0);
    send(tab[1], 1'b0, 6'd0);
    idle();
    @(negedge clk);
    check("full_in_ready", 32'(in_ready0), 32'd0);
    check("full_acc_nonzero", 32'(acc_q0), 32'd3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid0), 32'd0);
    check("async_rst_out_res",   32'(out_res0),   32'd0);
    check("async_rst_acc_q",     32'(acc_q0),     32'd0);
    check("async_rst_in_ready",  32'(in_ready0),  32'd1);
    q.delete();
    force_rdy = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready0), 32'd1);
    send(tab[5], 1'b0, 6'd0);
    idle();
    @(negedge clk);
    check("post_rst_gap", 32'(out_valid0), 32'd0);
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid0), 32'd1);
    @(posedge clk); #1;
    drain();

    check("beats_out",   32'(npop),     32'd22);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the 6-bit combinational ALU. It keeps the same four signed operations, and adds:
- generic operand width;
- optional saturation;
- status flags;
- an internal accumulator that can stand in for operand A;
- valid/ready handshakes with full backpressure.

It sits between an operand source and a result sink that may stall.

## Interface
- WIDTH, 6: two's-complement operand/result width (≥ 4).
- SATURATE, 0: 0 = results wrap modulo 2^WIDTH; 1 = results clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- in_a, in_b  in  WIDTH  signed operands.
- in_op  in  2  operation select.
- in_acc  in  1  use accumulator instead of in_a; write result back to accumulator.
- acc_clr  in  1  synchronous accumulator clear strobe (independent of handshake).
- out_valid  out  1  result beat held.
- out_ready  in  1  sink accepts result.
- out_res  out  WIDTH  signed result.
- out_ovf  out  1  exact result did not fit WIDTH bits.
- out_zero  out  1  out_res == 0.
- out_neg  out  1  out_res MSB.
- acc_q  out  WIDTH  current accumulator value.

## Operation
- Exact result is computed at WIDTH+3 signed bits, with A = accumulator if in_acc else in_a:
  - op 00: (A <<< 2) + (B >>> 1), where >>> is arithmetic.
  - op 01: A + 3·B.
  - op 10: −B.
  - op 11: |2·A − B|.
- Overflow and result:
  - ovf = exact result outside the WIDTH-bit signed range.
  - res = low WIDTH bits of the exact result (SATURATE=0), or the clamped value (SATURATE=1).
  - Flags are computed on the final res; ovf is reported in both modes.
- Stage 1 (S1) registers in_a, in_b, in_op and in_acc on handshake (in_valid & in_ready).
- Arithmetic is combinational from the S1 registers. S1→S2 transfer loads res and flags into the output register (S2).
- Accumulator update:
  - The accumulator is read at the S1→S2 transfer, not at input acceptance. Back-to-back accumulate beats therefore chain correctly with no hazard.
  - On an S1→S2 transfer with in_acc=1 registered, acc ← res (wrapped or saturated value).
- acc_clr rules:
  - acc_clr in a cycle without an accumulate transfer: acc ← 0.
  - acc_clr in the same cycle as an accumulate transfer: that transfer uses A = 0, then acc ← res.
  - acc_clr in the same cycle as a non-accumulate transfer: acc ← 0, and the transfer proceeds unaffected.
- Backpressure:
  - S2 advance = !s2_valid | out_ready.
  - S1 advance = s1_valid & S2 advance.
  - in_ready = !s1_valid | S2 advance (combinational, no input-to-output timing path other than via out_ready).
- No beat is dropped or duplicated. Output data and flags stay stable while out_valid & !out_ready.

## Timing
- Reset (rst_n low, asynchronous): all of the following are 0 until the first clk edge after rst_n deasserts:
  - out_valid, out_res, out_ovf, out_zero, out_neg;
  - acc_q and the S1/S2 valid bits.
- After reset, in_ready = 1.
- Reset mid-operation discards all in-flight beats and the accumulator.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1 if unstalled (2 registers, 1-cycle gap).
- Throughput: 1 beat/cycle with out_ready held high.
- Full condition: S1 and S2 both valid and out_ready low, so in_ready = 0. Raising out_ready restores in_ready combinationally in the same cycle.
- Empty: out_valid = 0, and out_res/flags hold their last values (don't-care for the sink).

## Test plan
1. WIDTH=6, SATURATE=0, op 00, A=3, B=5 → res 14, ovf 0. Same op with A=10, B=5 → exact 42: res −22, ovf 1, neg 1.
2. WIDTH=6, SATURATE=1:
   - op 10, B=−32 → res 31, ovf 1.
   - op 11, A=−16, B=1 → exact 33 → res 31, ovf 1.
   - Same two beats with SATURATE=0 → −32 and −31, both ovf 1.
3. Op 01, A=1, B=−3 → res −8, neg 1. Op 11, A=2, B=4 → res 0, zero 1.
4. Accumulate chain, out_ready=1:
   - acc_clr pulse, then back-to-back op 01 beats, in_acc=1, B=1.
   - Required: acc_q and outputs 3, 6, 9 on consecutive cycles.
   - acc_clr coincident with the third transfer → that result is 3.
5. Backpressure:
   - Stream 5 beats with out_ready held low.
   - in_ready drops after 2 accepted beats; out_res holds the first result.
   - Release out_ready for random patterns: all 5 results emerge in order, none lost or repeated.
6. Assert rst_n low asynchronously with both stages full and acc_q≠0:
   - out_valid, out_res and acc_q go to 0 immediately, without waiting for a clk edge.
   - in_ready = 1 after release; the next beat's result appears 2 edges later.
